// File: rtl/program_loader.sv
// program_loader
//   Byte-stream boot loader feeding the data-side write port of Memory.
//   Stream format (little-endian): 32-bit word count, then that many 32-bit
//   words. Each word is written once, in WORD mode, at consecutive word
//   addresses starting at BASE_ADDR. The CPU is held off while a load runs.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   start          : one-cycle pulse, starts a load from IDLE/DONE/ERROR
//   rxData/rxValid : incoming byte stream; rxReady is the accept side
//   address/data   : Memory write address/data, held between writes
//   writeMode      : Memory write mode, NONE except for one cycle per word
//   busy/cpuHold   : registered "load in progress"
//   done/error     : result of the last load
//   wordsWritten   : words written in the current/last load
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic        rxReady,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic [2:0]  writeMode,
  output logic        busy,
  output logic        cpuHold,
  output logic        done,
  output logic        error,
  output logic [31:0] wordsWritten
);

  // Encodings of MemoryModesPackage ReadWriteMode_NONE / ReadWriteMode_WORD.
  localparam logic [2:0] RW_NONE = 3'd0;
  localparam logic [2:0] RW_WORD = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] count_q, count_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ww_q, ww_d;
  logic        busy_q, busy_d;
  logic        rx_ready;
  logic        fire;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    count_d    = count_q;
    word_d     = word_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ww_d       = ww_q;
    rx_ready   = (state_q == S_LEN) || (state_q == S_DATA);
    fire       = rxValid && rx_ready;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN;
          byte_cnt_d = 2'd0;
          count_d    = 32'd0;
          ww_d       = 32'd0;
        end
      end
      S_LEN: begin
        if (fire) begin
          // Shift in from the top: after four bytes the first one sits in [7:0].
          count_d    = {rxData, count_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (count_d == 32'd0)                 state_d = S_DONE;
            else if (count_d > 32'(MAX_WORDS))    state_d = S_ERROR;
            else                                  state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          word_d     = {rxData, word_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Address/data are loaded here so they are stable for the whole
            // WRITE cycle and then simply hold until the next word.
            addr_d  = BASE_ADDR + {ww_q[29:0], 2'b00};
            data_d  = word_d;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        ww_d    = ww_q + 32'd1;
        state_d = (ww_d == count_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      count_q    <= 32'd0;
      word_q     <= 32'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      ww_q       <= 32'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      count_q    <= count_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ww_q       <= ww_d;
      busy_q     <= busy_d;
    end
  end

  assign rxReady      = rx_ready;
  assign address      = addr_q;
  assign data         = data_q;
  assign writeMode    = (state_q == S_WRITE) ? RW_WORD : RW_NONE;
  assign busy         = busy_q;
  assign cpuHold      = busy_q;
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign wordsWritten = ww_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed bench for program_loader: a cycle table for the basic two-word
//   load, then hand-written sequences for stalls, zero/oversize/limit counts,
//   reset mid-load, ignored start and last-word timing. A small word memory
//   captures every WORD cycle as Memory would.
module tb_program_loader;

  localparam logic [2:0] WM_NONE = 3'd0;
  localparam logic [2:0] WM_WORD = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic [31:0] address;
  logic [31:0] data;
  logic [2:0]  writeMode;
  logic        busy;
  logic        cpuHold;
  logic        done;
  logic        error;
  logic [31:0] wordsWritten;

  program_loader dut (
    .clk(clk), .rst(rst), .start(start), .rxData(rxData), .rxValid(rxValid),
    .rxReady(rxReady), .address(address), .data(data), .writeMode(writeMode),
    .busy(busy), .cpuHold(cpuHold), .done(done), .error(error),
    .wordsWritten(wordsWritten)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Memory stand-in: captures data on the edge that ends a WORD cycle.
  logic [31:0] mem [0:15] = '{default: 32'd0};
  int nwr = 0;
  always @(posedge clk) begin
    if (writeMode == WM_WORD) begin
      mem[address[5:2]] <= data;
      nwr <= nwr + 1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {24'd0, rxReady, writeMode, address, data, busy, cpuHold, done, error, wordsWritten};
  endfunction

  typedef struct {
    logic        st;
    logic        vld;
    logic [7:0]  b;
    logic        rdy;
    logic [2:0]  wm;
    logic [31:0] addr;
    logic [31:0] dat;
    logic        bsy;
    logic        dn;
    logic        er;
    logic [31:0] ww;
  } vec_t;

  function automatic vec_t mk(logic st, logic vld, logic [7:0] b, logic rdy, logic [2:0] wm,
                              logic [31:0] addr, logic [31:0] dat, logic bsy, logic dn,
                              logic er, logic [31:0] ww);
    vec_t v;
    v.st = st; v.vld = vld; v.b = b; v.rdy = rdy; v.wm = wm; v.addr = addr;
    v.dat = dat; v.bsy = bsy; v.dn = dn; v.er = er; v.ww = ww;
    return v;
  endfunction

  function automatic logic [127:0] exp_of(vec_t v);
    return {24'd0, v.rdy, v.wm, v.addr, v.dat, v.bsy, v.bsy, v.dn, v.er, v.ww};
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    rxValid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte after `gap` idle cycles and returns just after the
  // rising edge that accepted it; rxValid stays high with the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      rxValid = 1'b0;
    end
    @(negedge clk);
    rxValid = 1'b1;
    rxData = b;
    n = 0;
    while (!rxReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rxReady) begin
      failures++;
      checks++;
      $display("FAIL send_byte_timeout actual=rxReady_low expected=rxReady_high");
    end
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], stall ? int'($urandom_range(1, 3)) : 0);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {127'd0, done}, 128'd1);
  endtask

  vec_t tv [17];
  int   nwr0;

  initial begin
    rst = 1'b1; start = 1'b0; rxValid = 1'b0; rxData = 8'h00;

    // Basic load, one row per cycle: inputs for the coming edge, outputs now.
    tv[0]  = mk(1, 0, 8'h00, 0, WM_NONE, 0, 0,            0, 0, 0, 0);
    tv[1]  = mk(0, 1, 8'h02, 1, WM_NONE, 0, 0,            1, 0, 0, 0);
    tv[2]  = mk(0, 1, 8'h00, 1, WM_NONE, 0, 0,            1, 0, 0, 0);
    tv[3]  = mk(0, 1, 8'h00, 1, WM_NONE, 0, 0,            1, 0, 0, 0);
    tv[4]  = mk(0, 1, 8'h00, 1, WM_NONE, 0, 0,            1, 0, 0, 0);
    tv[5]  = mk(0, 1, 8'h78, 1, WM_NONE, 0, 0,            1, 0, 0, 0);
    tv[6]  = mk(0, 1, 8'h56, 1, WM_NONE, 0, 0,            1, 0, 0, 0);
    tv[7]  = mk(0, 1, 8'h34, 1, WM_NONE, 0, 0,            1, 0, 0, 0);
    tv[8]  = mk(0, 1, 8'h12, 1, WM_NONE, 0, 0,            1, 0, 0, 0);
    tv[9]  = mk(0, 1, 8'hDD, 0, WM_WORD, 0, 32'h12345678, 1, 0, 0, 0);
    tv[10] = mk(0, 1, 8'hDD, 1, WM_NONE, 0, 32'h12345678, 1, 0, 0, 1);
    tv[11] = mk(0, 1, 8'hCC, 1, WM_NONE, 0, 32'h12345678, 1, 0, 0, 1);
    tv[12] = mk(0, 1, 8'hBB, 1, WM_NONE, 0, 32'h12345678, 1, 0, 0, 1);
    tv[13] = mk(0, 1, 8'hAA, 1, WM_NONE, 0, 32'h12345678, 1, 0, 0, 1);
    tv[14] = mk(0, 0, 8'h00, 0, WM_WORD, 4, 32'hAABBCCDD, 1, 0, 0, 1);
    tv[15] = mk(0, 0, 8'h00, 0, WM_NONE, 4, 32'hAABBCCDD, 0, 1, 0, 2);
    tv[16] = mk(0, 0, 8'h00, 0, WM_NONE, 4, 32'hAABBCCDD, 0, 1, 0, 2);

    #3;
    chk("reset_values", outs(), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      start = tv[i].st; rxValid = tv[i].vld; rxData = tv[i].b;
      #1;
      chk($sformatf("basic_cycle_%0d", i), outs(), exp_of(tv[i]));
    end
    chk("basic_mem", {64'd0, mem[0], mem[1]}, {64'd0, 32'h12345678, 32'hAABBCCDD});
    chk("basic_nwr", 128'(nwr), 128'd2);

    // Asynchronous reset from DONE with non-zero address/data.
    @(negedge clk);
    rxValid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("async_reset", outs(), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {127'd0, rxReady}, 128'd0);

    // Stalled source: same stream with random gaps.
    mem[0] = 32'd0; mem[1] = 32'd0;
    nwr0 = nwr;
    pulse_start();
    send_word(32'd2, 1);
    send_word(32'h12345678, 1);
    send_word(32'hAABBCCDD, 1);
    wait_done("stall_done");
    chk("stall_mem", {64'd0, mem[0], mem[1]}, {64'd0, 32'h12345678, 32'hAABBCCDD});
    chk("stall_ww_nwr", {64'd0, wordsWritten, 32'(nwr - nwr0)}, {64'd0, 32'd2, 32'd2});

    // Zero count: done at the edge after the 4th length byte, no writes.
    nwr0 = nwr;
    pulse_start();
    send_word(32'd0, 0);
    #1 chk("zero_done", {126'd0, done, busy}, {126'd0, 1'b1, 1'b0});
    @(negedge clk);
    chk("zero_nwr", 128'(nwr - nwr0), 128'd0);

    // Oversize count (MAX_WORDS+1).
    pulse_start();
    send_word(32'd16385, 0);
    #1 chk("oversize_err", {125'd0, error, rxReady, busy}, {125'd0, 3'b100});
    @(negedge clk);
    chk("oversize_nwr", 128'(nwr - nwr0), 128'd0);
    chk("oversize_mem", {32'd0, mem[0], mem[1], mem[2]},
        {32'd0, 32'h12345678, 32'hAABBCCDD, 32'd0});

    // A valid load after the error.
    pulse_start();
    chk("restart_clears_err", {126'd0, error, busy}, {126'd0, 1'b0, 1'b1});
    send_word(32'd1, 0);
    send_word(32'hCAFEF00D, 0);
    wait_done("reload_done");
    chk("reload_mem", {64'd0, mem[0], wordsWritten}, {64'd0, 32'hCAFEF00D, 32'd1});

    // Count exactly MAX_WORDS is accepted.
    pulse_start();
    send_word(32'd16384, 0);
    #1 chk("limit_count", {125'd0, busy, error, rxReady}, {125'd0, 3'b101});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Reset after two bytes of word 1 in a 3-word load.
    pulse_start();
    send_word(32'd3, 0);
    send_word(32'hDEADBEEF, 0);
    send_byte(8'hEE, 0);
    send_byte(8'h77, 0);
    @(negedge clk);
    rxValid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("midload_reset", outs(), 128'd0);
    chk("midload_word0_kept", {96'd0, mem[0]}, {96'd0, 32'hDEADBEEF});
    @(negedge clk);
    rst = 1'b0;

    // Full rewrite with an ignored start during DATA and last-word timing.
    nwr0 = nwr;
    pulse_start();
    send_word(32'd3, 0);
    send_word(32'h01020304, 0);
    send_byte(8'h08, 0);
    pulse_start();
    chk("ignored_start", {126'd0, busy, wordsWritten[0]}, {126'd0, 1'b1, 1'b1});
    send_byte(8'h07, 0);
    send_byte(8'h06, 0);
    send_byte(8'h05, 0);
    send_word(32'h090A0B0C, 0);
    #1 chk("last_word_pulse", {124'd0, writeMode, done}, {124'd0, WM_WORD, 1'b0});
    @(posedge clk);
    #1 chk("last_word_done", {123'd0, writeMode, done, busy}, {123'd0, WM_NONE, 1'b1, 1'b0});
    @(negedge clk);
    rxValid = 1'b0;
    chk("rewrite_mem", {32'd0, mem[0], mem[1], mem[2]},
        {32'd0, 32'h01020304, 32'h05060708, 32'h090A0B0C});
    chk("rewrite_ww_nwr", {64'd0, wordsWritten, 32'(nwr - nwr0)}, {64'd0, 32'd3, 32'd3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
